// File: rtl/field_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | field_pkg                                                            |
// | Shared defaults, derived widths and state encoding for the unpacker. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package field_pkg;

  localparam int FIELD_W    = 2;
  localparam int NUM_FIELDS = 5;
  localparam int WORD_W     = FIELD_W * NUM_FIELDS;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/field_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | field_shift_reg                                                      |
// | Loadable left-shift register exposing its most-significant field.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module field_shift_reg #(
  parameter int FIELD_W    = field_pkg::FIELD_W,
  parameter int NUM_FIELDS = field_pkg::NUM_FIELDS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_load,
  input  logic                          i_shift,
  input  logic [FIELD_W*NUM_FIELDS-1:0] i_load_data,
  output logic [FIELD_W-1:0]            o_top_field
);

  localparam int c_word_w = FIELD_W * NUM_FIELDS;

  logic [c_word_w-1:0] r_data;

  // Load wins over shift so a new word can replace the last field in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
    end else if (i_shift) begin
      r_data <= {r_data[c_word_w-FIELD_W-1:0], {FIELD_W{1'b0}}};
    end
  end

  assign o_top_field = r_data[c_word_w-1 -: FIELD_W];

endmodule
`default_nettype wire

// File: rtl/field_unpacker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | field_unpacker                                                       |
// | Splits a packed word into fields, emitted MS field first, one a beat.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module field_unpacker #(
  parameter int FIELD_W    = field_pkg::FIELD_W,
  parameter int NUM_FIELDS = field_pkg::NUM_FIELDS,
  parameter int IDX_W      = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FIELD_W*NUM_FIELDS-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FIELD_W-1:0]            out_field,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_last,
  output logic [7:0]                    word_cnt
);

  import field_pkg::*;

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_FIELDS - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_idx;
  logic [7:0]         r_word_cnt;
  logic               w_emit;
  logic               w_last;
  logic               w_out_fire;
  logic               w_in_fire;
  logic [FIELD_W-1:0] w_top_field;

  assign w_emit     = (r_state == EMIT);
  assign w_last     = (r_idx == c_last_idx);
  assign w_out_fire = w_emit & out_ready;
  assign w_in_fire  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_in_fire) w_next_state = EMIT;
      EMIT: if (w_out_fire && w_last && !w_in_fire) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // in_ready is gated by rst_n so nothing is advertised while held in reset.
  always_comb begin
    out_valid = w_emit;
    in_ready  = rst_n & (~w_emit | (w_out_fire & w_last));
    out_field = w_top_field;
    out_idx   = r_idx;
    out_last  = w_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_in_fire) begin
      r_idx <= '0;
    end else if (w_out_fire) begin
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= 8'd0;
    end else if (w_out_fire && w_last) begin
      r_word_cnt <= r_word_cnt + 8'd1;
    end
  end

  assign word_cnt = r_word_cnt;

  // Shifting on the final beat too leaves the register zeroed once idle.
  field_shift_reg #(
    .FIELD_W    (FIELD_W),
    .NUM_FIELDS (NUM_FIELDS)
  ) u_shift_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_in_fire),
    .i_shift     (w_out_fire),
    .i_load_data (in_data),
    .o_top_field (w_top_field)
  );

endmodule
`default_nettype wire

// File: tb/tb_field_unpacker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_field_unpacker                                                    |
// | Self-checking bench: vector table plus scoreboard of expected beats. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_field_unpacker;

  localparam int FW = 2;
  localparam int NF = 5;
  localparam int IW = 3;
  localparam int WW = FW * NF;

  typedef logic [NF-1:0][FW-1:0] fields_t;

  typedef struct packed {
    logic [FW-1:0] field;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  typedef struct {
    logic [WW-1:0] data;
    fields_t       exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [FW-1:0] out_field;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic [7:0]    word_cnt;

  int     n_checks = 0;
  int     n_errors = 0;
  int     gap_cnt  = 0;
  beat_t  sb[$];
  beat_t  mon_e;
  logic   mon_rdy;
  vec_t   vecs[4];
  int     waited;

  field_unpacker #(
    .FIELD_W    (FW),
    .NUM_FIELDS (NF),
    .IDX_W      (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_field (out_field),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic fields_t mk(input logic [FW-1:0] f0, f1, f2, f3, f4);
    return {f4, f3, f2, f1, f0};
  endfunction

  function automatic fields_t split(input logic [WW-1:0] d);
    fields_t r;
    for (int k = 0; k < NF; k++) r[k] = d[WW-1-k*FW -: FW];
    return r;
  endfunction

  task automatic push_word(input fields_t f);
    for (int k = 0; k < NF; k++) sb.push_back('{field: f[k], idx: IW'(k), last: (k == NF-1)});
  endtask

  // Present a word and hold it until accepted; waits counts negedges spent stalled.
  task automatic send_word(input logic [WW-1:0] d, input fields_t f, output int waits);
    waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance of %0h", d);
      in_valid = 1'b0;
    end else begin
      push_word(f);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("drain_timeout", 32'(n < 300), 1);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        mon_rdy = out_ready && (sb.size() > 0) && sb[0].last;
        check("in_ready_emit", in_ready, mon_rdy);
        if (out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat: got field %0h idx %0h expected no beat", out_field, out_idx);
          end else begin
            mon_e = sb.pop_front();
            check("out_field", out_field, mon_e.field);
            check("out_idx",   out_idx,   mon_e.idx);
            check("out_last",  out_last,  mon_e.last);
          end
        end
      end else begin
        check("in_ready_idle", in_ready, 1);
        if (in_valid) gap_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{data: 10'h06D, exp: mk(2'd0, 2'd1, 2'd2, 2'd3, 2'd1)};
    vecs[1] = '{data: 10'h2C9, exp: mk(2'd2, 2'd3, 2'd0, 2'd2, 2'd1)};
    vecs[2] = '{data: 10'h0E4, exp: mk(2'd0, 2'd3, 2'd2, 2'd1, 2'd0)};
    vecs[3] = '{data: 10'h155, exp: mk(2'd1, 2'd1, 2'd1, 2'd1, 2'd1)};

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_field", out_field, 0);
    check("rst_out_idx",   out_idx,   0);
    check("rst_out_last",  out_last,  0);
    check("rst_word_cnt",  word_cnt,  0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Table of single words, each drained before the next.
    for (int i = 0; i < 4; i++) begin
      send_word(vecs[i].data, vecs[i].exp, waited);
      if (i == 0) begin
        check("latency_valid", out_valid, 1);
        check("latency_idx",   out_idx,   0);
        check("latency_field", out_field, 0);
      end
      drain();
      check("word_cnt_table", word_cnt, 32'(i + 1));
    end

    // Back-to-back words.
    send_word(10'h3FF, mk(2'd3, 2'd3, 2'd3, 2'd3, 2'd3), waited);
    send_word(10'h000, mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd0), waited);
    check("b2b_accept_waits", waited, 4);
    for (int k = 0; k < NF; k++) begin
      @(negedge clk);
      check("b2b_no_bubble", out_valid, 1);
    end
    drain();
    check("word_cnt_b2b", word_cnt, 6);

    // Backpressure at idx 2.
    send_word(10'h06D, vecs[0].exp, waited);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_field", out_field, 2);
      check("bp_idx",   out_idx,   2);
      check("bp_last",  out_last,  0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    check("word_cnt_bp", word_cnt, 7);

    // Busy input: second word held until the final beat of the first.
    send_word(10'h06D, vecs[0].exp, waited);
    send_word(10'h155, vecs[3].exp, waited);
    check("busy_accept_waits", waited, 4);
    drain();
    check("word_cnt_busy", word_cnt, 9);

    // Asynchronous reset in the middle of a word.
    send_word(10'h2C9, vecs[1].exp, waited);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_word_cnt",  word_cnt,  0);
    check("midrst_in_ready",  in_ready,  0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("midrst_no_beats", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // 256 streamed words wrap the counter; only the first acceptance sees idle.
    gap_cnt = 0;
    for (int w = 0; w < 256; w++) begin
      logic [WW-1:0] d;
      d = WW'($urandom_range(0, (1 << WW) - 1));
      send_word(d, split(d), waited);
    end
    drain();
    check("wrap_word_cnt", word_cnt, 0);
    check("wrap_gap_cnt",  gap_cnt,  1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
